// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the multiply/divide scheduler: operation codes
//   presented on md_op, the FSM state encoding, and small op-decode helpers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package muldiv_pkg;

    // Operation codes carried on md_op.
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;

    // FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_MUL  = 2'd1;
    localparam state_t S_DIV  = 2'd2;
    localparam state_t S_DONE = 2'd3;

    // True for the two multiply flavours; every other code runs the divider.
    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // True for the two-complement flavours (MULT, DIV).
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sched_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring radix-2 divide step on unsigned magnitudes.
//   The partial remainder is shifted left by one, pulling in the next dividend
//   bit from the top of the quotient register; if the divisor fits it is
//   subtracted and a 1 is shifted into the quotient, otherwise a 0.
//
// Ports
//   i_rem      in   WIDTH  current partial remainder
//   i_quot     in   WIDTH  remaining dividend bits / quotient built so far
//   i_divisor  in   WIDTH  divisor magnitude
//   o_rem      out  WIDTH  next partial remainder
//   o_quot     out  WIDTH  next quotient register
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_sub;

    assign w_shift = {i_rem, i_quot[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, i_divisor});
    // When the divisor fits, the true difference is below 2^WIDTH, so the
    // low WIDTH bits of a WIDTH-bit subtraction are exact.
    assign w_sub   = w_shift[WIDTH-1:0] - i_divisor;

    assign o_rem  = w_fits ? w_sub : w_shift[WIDTH-1:0];
    assign o_quot = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
//   Sequences the shared multiply/divide unit that writes the HI/LO pair for
//   MULT/MULTU/DIV/DIVU. It sits in the execute stage, accepts one op per
//   issue, holds stall_o while the op runs, then pulses hilo_we_o for one
//   cycle with the result on hi_o/lo_o. Multiply is a product registered on
//   accept followed by MUL_LAT cycles in MUL; divide is restoring radix-2,
//   one quotient bit per cycle. Signed ops work on magnitudes and fix signs
//   on the way out.
//
// Configuration macro
//   MULDIV_EARLY_OUT_EN  when defined, a DIV whose divisor is zero or whose
//                        |dividend| < |divisor| finishes after one DIV cycle
//                        with the same result the full iteration would give.
//
// Ports
//   clk        in   1      pipeline clock
//   rst        in   1      asynchronous, active-high reset
//   flushE     in   1      annul execute-stage op; abort an op in MUL/DIV
//   md_valid   in   1      execute stage holds a mul/div op
//   md_op      in   3      MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
//   srca       in   WIDTH  multiplicand / dividend
//   srcb       in   WIDTH  multiplier / divisor
//   stall_o    out  1      freeze F/D/E (combinational)
//   busy_o     out  1      FSM not IDLE (registered)
//   hilo_we_o  out  1      one-cycle HI/LO write strobe (high in DONE)
//   hi_o       out  WIDTH  product high half or remainder
//   lo_o       out  WIDTH  product low half or quotient
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flushE,
    input  logic             md_valid,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // Counter sized for the longer of the two iteration counts.
    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_INIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_busy;
    logic [CW-1:0]    r_count;
    // {r_rem, r_quot} holds the signed-corrected product during MUL and the
    // restoring-divide working pair during DIV.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_quot;
    logic               w_early;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_r;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_to_done;

    // ---------------- operand decode ----------------
    assign w_accept    = md_valid & ~flushE & (r_state == S_IDLE);
    assign w_is_mul    = op_is_mul(md_op);
    assign w_is_signed = op_is_signed(md_op);
    assign w_sign_a    = w_is_signed & srca[WIDTH-1];
    assign w_sign_b    = w_is_signed & srcb[WIDTH-1];
    // -2^(W-1) maps onto itself, which is the correct unsigned magnitude.
    assign w_mag_a     = w_sign_a ? -srca : srca;
    assign w_mag_b     = w_sign_b ? -srcb : srcb;

    assign w_prod_mag = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
    assign w_prod     = (w_sign_a ^ w_sign_b) ? -w_prod_mag : w_prod_mag;

    // ---------------- divider datapath ----------------
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quot    (w_step_quot)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // On the first DIV cycle r_quot still holds |dividend|. A zero divisor
    // yields an all-ones quotient; a larger divisor yields zero. Either way
    // the remainder is the dividend itself.
    assign w_early = (r_count == DIV_INIT) &&
                     ((r_divisor == '0) || (r_quot < r_divisor));
    assign w_q_mag = w_early ? {WIDTH{r_divisor == '0}} : w_step_quot;
    assign w_r_mag = w_early ? r_quot : w_step_rem;
`else
    assign w_early = 1'b0;
    assign w_q_mag = w_step_quot;
    assign w_r_mag = w_step_rem;
`endif

    assign w_div_q = r_neg_q ? -w_q_mag : w_q_mag;
    assign w_div_r = r_neg_r ? -w_r_mag : w_r_mag;

    assign w_res_hi  = (r_state == S_MUL) ? r_rem  : w_div_r;
    assign w_res_lo  = (r_state == S_MUL) ? r_quot : w_div_q;
    // DONE is only ever entered from MUL or DIV, and only when not flushed.
    assign w_to_done = (w_next_state == S_DONE);

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not assign it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_is_mul ? S_MUL : S_DIV;
            S_MUL: begin
                if (flushE)                w_next_state = S_IDLE;
                else if (r_count == '0)    w_next_state = S_DONE;
            end
            S_DIV: begin
                if (flushE)                        w_next_state = S_IDLE;
                else if (r_count == '0 || w_early) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // stall_o drops in DONE so the op leaves E on the same edge HI/LO commit.
    always_comb begin
        stall_o   = 1'b0;
        hilo_we_o = 1'b0;
        case (r_state)
            S_IDLE:  stall_o   = md_valid & ~flushE;
            S_MUL:   stall_o   = 1'b1;
            S_DIV:   stall_o   = 1'b1;
            S_DONE:  hilo_we_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o = r_busy;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

    // ---------------- datapath registers ----------------
    // NOTE: the datapath is reset along with the FSM so hi_o/lo_o read zero
    // out of reset and no X can reach the HI/LO write path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_neg_q   <= w_sign_a ^ w_sign_b;
                        r_neg_r   <= w_sign_a;
                        r_divisor <= w_mag_b;
                        if (w_is_mul) begin
                            r_count         <= MUL_INIT;
                            {r_rem, r_quot} <= w_prod;
                        end else begin
                            r_count <= DIV_INIT;
                            r_rem   <= '0;
                            r_quot  <= w_mag_a;
                        end
                    end
                end
                S_MUL: begin
                    if (r_count != '0) r_count <= r_count - CW'(1);
                end
                S_DIV: begin
                    r_rem  <= w_step_rem;
                    r_quot <= w_step_quot;
                    if (r_count != '0) r_count <= r_count - CW'(1);
                end
                default: ;
            endcase

            // hi_o/lo_o hold their value until the next completed op.
            if (w_to_done) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
`timescale 1ns/1ps
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flushE;
    logic         md_valid;
    logic [2:0]   md_op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         stall_o;
    logic         busy_o;
    logic         hilo_we_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    always #5 clk = ~clk;

    muldiv_sched #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .flushE    (flushE),
        .md_valid  (md_valid),
        .md_op     (md_op),
        .srca      (srca),
        .srcb      (srcb),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .hilo_we_o (hilo_we_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res = '0;

    // Reference model: {HI, LO} for an op, from the architectural definition.
    function automatic logic [2*W-1:0] model(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [2*W-1:0] sp;
        logic signed [W-1:0]   sq;
        logic signed [W-1:0]   sr;
        case (op)
            MD_MULT: begin
                sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                return sp;
            end
            MD_MULTU: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            MD_DIV: begin
                if (b == '0) return {a, (a[W-1] ? 32'd1 : 32'hFFFF_FFFF)};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        md_valid = 1'b1;
        md_op    = op;
        srca     = a;
        srcb     = b;
    endtask

    task automatic idle_inputs();
        md_valid = 1'b0;
        md_op    = MD_MULT;
        srca     = '0;
        srcb     = '0;
    endtask

    // Waits for the strobe; counts the stalled cycles before it.
    task automatic wait_strobe(input int budget, output int stalls, output bit seen);
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (hilo_we_o) seen = 1'b1;
            else if (stall_o) stalls++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flushE = 1'b0;
        idle_inputs();
        #2;
        n_checks++;
        if ({stall_o, busy_o, hilo_we_o, hi_o, lo_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b busy=%b we=%b hi=%h lo=%h want all zero",
                     stall_o, busy_o, hilo_we_o, hi_o, lo_o);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({stall_o, busy_o, hilo_we_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got stall=%b busy=%b we=%b want 000",
                     stall_o, busy_o, hilo_we_o);
        end
    endtask

    task automatic test_mult();
        int stalls;
        bit seen;
        logic [2*W-1:0] exp;
        @(posedge clk); #1;
        drive(MD_MULT, -32'sd3, 32'd5);
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
        wait_strobe(100, stalls, seen);
        exp = exp_q.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mult_strobe: no hilo_we_o within 100 cycles");
        end else begin
            n_checks += 3;
            if ({hi_o, lo_o} !== exp) begin
                n_fail++;
                $display("FAIL mult_result: got hi=%h lo=%h want hi=%h lo=%h",
                         hi_o, lo_o, exp[2*W-1:W], exp[W-1:0]);
            end
            if (stalls != MUL_LAT + 1) begin
                n_fail++;
                $display("FAIL mult_stall_cycles: got %0d want %0d", stalls, MUL_LAT + 1);
            end
            if (stall_o !== 1'b0) begin
                n_fail++;
                $display("FAIL mult_stall_on_strobe: got %b want 0", stall_o);
            end
            last_res = exp;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_divide();
        logic [2:0]   t_op [6];
        logic [W-1:0] t_a  [6];
        logic [W-1:0] t_b  [6];
        logic [2*W-1:0] t_exp [6];
        int           t_lat[6];
        t_op[0] = MD_DIVU; t_a[0] = 32'd100;        t_b[0] = 32'd7;
        t_exp[0] = {32'd2, 32'd14};                          t_lat[0] = W + 1;
        t_op[1] = MD_DIV;  t_a[1] = -32'sd7;        t_b[1] = 32'd2;
        t_exp[1] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};           t_lat[1] = W + 1;
        t_op[2] = MD_DIV;  t_a[2] = 32'h8000_0000;  t_b[2] = 32'hFFFF_FFFF;
        t_exp[2] = {32'd0, 32'h8000_0000};                   t_lat[2] = W + 1;
        t_op[3] = MD_DIV;  t_a[3] = -32'sd3;        t_b[3] = 32'd7;
        t_exp[3] = {32'hFFFF_FFFD, 32'd0};                   t_lat[3] = EARLY_LAT;
        t_op[4] = MD_DIVU; t_a[4] = 32'd5;          t_b[4] = 32'd0;
        t_exp[4] = {32'd5, 32'hFFFF_FFFF};                   t_lat[4] = EARLY_LAT;
        t_op[5] = MD_DIV;  t_a[5] = -32'sd5;        t_b[5] = 32'd0;
        t_exp[5] = {32'hFFFF_FFFB, 32'd1};                   t_lat[5] = EARLY_LAT;
        for (int i = 0; i < 6; i++) begin
            int stalls;
            bit seen;
            logic [2*W-1:0] exp;
            @(posedge clk); #1;
            drive(t_op[i], t_a[i], t_b[i]);
            exp_q.push_back(t_exp[i]);
            wait_strobe(100, stalls, seen);
            exp = exp_q.pop_front();
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL div%0d_strobe: no hilo_we_o within 100 cycles", i);
            end else begin
                n_checks += 3;
                if ({hi_o, lo_o} !== exp) begin
                    n_fail++;
                    $display("FAIL div%0d_result: got hi=%h lo=%h want hi=%h lo=%h",
                             i, hi_o, lo_o, exp[2*W-1:W], exp[W-1:0]);
                end
                if (stalls != t_lat[i]) begin
                    n_fail++;
                    $display("FAIL div%0d_latency: got %0d want %0d", i, stalls, t_lat[i]);
                end
                if (stall_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL div%0d_stall_on_strobe: got %b want 0", i, stall_o);
                end
                last_res = exp;
            end
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    task automatic test_flush();
        int strobes = 0;
        @(posedge clk); #1;
        drive(MD_DIVU, 32'd1000, 32'd3);
        // Accept edge, then nine more edges: now in the tenth DIV iteration.
        repeat (10) @(posedge clk);
        #1;
        flushE = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        flushE = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if ({stall_o, busy_o, hilo_we_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_idle: got stall=%b busy=%b we=%b want 000",
                     stall_o, busy_o, hilo_we_o);
        end
        if ({hi_o, lo_o} !== last_res) begin
            n_fail++;
            $display("FAIL flush_hold: got hi=%h lo=%h want hi=%h lo=%h",
                     hi_o, lo_o, last_res[2*W-1:W], last_res[W-1:0]);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hilo_we_o) strobes++;
        end
        n_checks++;
        if (strobes != 0) begin
            n_fail++;
            $display("FAIL flush_no_write: got %0d strobes want 0", strobes);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        drive(MD_DIVU, 32'd50, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({stall_o, busy_o, hilo_we_o, hi_o, lo_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got stall=%b busy=%b we=%b hi=%h lo=%h want all zero",
                     stall_o, busy_o, hilo_we_o, hi_o, lo_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = '0;
    endtask

    task automatic test_back_to_back();
        int stalls;
        bit seen;
        logic [2*W-1:0] exp;
        @(posedge clk); #1;
        drive(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        exp_q.push_back({32'd1, 32'hFFFF_FFFE});
        wait_strobe(100, stalls, seen);
        exp = exp_q.pop_front();
        n_checks++;
        if (!seen || {hi_o, lo_o} !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: seen=%b got hi=%h lo=%h want hi=%h lo=%h",
                     seen, hi_o, lo_o, exp[2*W-1:W], exp[W-1:0]);
        end
        // Pipeline advances on the edge closing DONE and presents the next op.
        @(posedge clk); #1;
        drive(MD_DIVU, 32'd9, 32'd3);
        exp_q.push_back({32'd0, 32'd3});
        @(negedge clk);
        n_checks++;
        if ({busy_o, stall_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_idle_accept: got busy=%b stall=%b want busy=0 stall=1",
                     busy_o, stall_o);
        end
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accepted: got busy=%b want 1", busy_o);
        end
        wait_strobe(100, stalls, seen);
        exp = exp_q.pop_front();
        n_checks++;
        if (!seen || {hi_o, lo_o} !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: seen=%b got hi=%h lo=%h want hi=%h lo=%h",
                     seen, hi_o, lo_o, exp[2*W-1:W], exp[W-1:0]);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int stalls;
            bit seen;
            logic [2:0]     op;
            logic [W-1:0]   a;
            logic [W-1:0]   b;
            logic [2*W-1:0] exp;
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
            @(posedge clk); #1;
            drive(op, a, b);
            exp_q.push_back(model(op, a, b));
            wait_strobe(100, stalls, seen);
            exp = exp_q.pop_front();
            n_checks++;
            if (!seen || {hi_o, lo_o} !== exp) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: seen=%b got hi=%h lo=%h want hi=%h lo=%h",
                         i, op, a, b, seen, hi_o, lo_o, exp[2*W-1:W], exp[W-1:0]);
            end
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_divide();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
